// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg: shared FSM state encoding and the add-3 correction threshold
package bin_to_bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
endpackage

// File: rtl/bin_to_bcd_add3.sv
// bcd_add3: one double-dabble digit correction, adds 3 when the digit is >= 5
//   i_digit  in  4  working BCD digit before the shift
//   o_digit  out 4  corrected digit
module bcd_add3
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);
  assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble binary to packed BCD converter
//   clk    in  1          rising-edge clock
//   rst_n  in  1          asynchronous active-low reset
//   bin    in  BIN_WIDTH  operand, sampled when start is accepted
//   start  in  1          conversion request, accepted only while ready
//   ready  out 1          high while idle
//   done   out 1          one-cycle pulse when bcd holds a new result
//   bcd    out 4*DIGITS   packed BCD result, digit 0 in [3:0]
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 10,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_WIDTH-1:0]  bin,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(BIN_WIDTH + 1);
  state_t                r_state, w_state_n;
  logic [BIN_WIDTH-1:0]  r_bin, w_bin_n;
  logic [4*DIGITS-1:0]   r_work, w_work_n, r_bcd, w_bcd_n, w_adj, w_work_sh;
  logic [CW-1:0]         r_cnt, w_cnt_n;
  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (.i_digit(r_work[4*d +: 4]), .o_digit(w_adj[4*d +: 4]));
  end
  // corrected digits shifted left with the operand MSB entering digit 0
  assign w_work_sh = {w_adj[4*DIGITS-2:0], r_bin[BIN_WIDTH-1]};
  always_comb begin
    w_state_n = r_state;
    w_bin_n   = r_bin;
    w_work_n  = r_work;
    w_cnt_n   = r_cnt;
    w_bcd_n   = r_bcd;
    case (r_state)
      IDLE: if (start) begin
        w_state_n = SHIFT;
        w_bin_n   = bin;
        w_work_n  = '0;
        w_cnt_n   = CW'(BIN_WIDTH);
      end
      SHIFT: begin
        w_bin_n  = r_bin << 1;
        w_work_n = w_work_sh;
        w_cnt_n  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_n = DONE;
          w_bcd_n   = w_work_sh;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_state_n;
      r_bin   <= w_bin_n;
      r_work  <= w_work_n;
      r_cnt   <= w_cnt_n;
      r_bcd   <= w_bcd_n;
    end
  end
  assign ready = (r_state == IDLE);
  assign done  = (r_state == DONE);
  assign bcd   = r_bcd;
endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter BIN_WIDTH, default 10, binary operand width; matches the Fibonacci result width at DATA_WIDTH=4.
REQ-002 Parameter DIGITS, default 4, number of BCD output digits; configurations with 10^DIGITS <= 2^BIN_WIDTH-1 are unsupported.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 bin  input  BIN_WIDTH  unsigned binary operand, sampled only on accepted start.
REQ-006 start  input  1  conversion request, one-cycle or held; accepted only when ready=1.
REQ-007 ready  output  1  high iff FSM in IDLE.
REQ-008 done  output  1  one-cycle pulse, result valid on bcd.
REQ-009 bcd  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0], most significant digit on top.

Function
REQ-010 FSM states SHALL be IDLE, SHIFT, DONE; no other reachable states.
REQ-011 IDLE with start=1 SHALL load bin into a shift register, clear the BCD working register, load the bit counter with BIN_WIDTH, and go to SHIFT.
REQ-012 IDLE with start=0 SHALL hold all registers.
REQ-013 Each SHIFT cycle SHALL add 3 to every working digit >= 5, then shift {digits, binary} left by one, MSB of binary entering digit 0 bit 0, and decrement the counter.
REQ-014 SHIFT SHALL go to DONE on the cycle the counter equals 1, after performing that cycle's shift; SHIFT lasts exactly BIN_WIDTH cycles.
REQ-015 On SHIFT->DONE the final working digits SHALL be copied into the result register driving bcd.
REQ-016 bcd SHALL change only on SHIFT->DONE and on reset; it holds the previous result during a conversion.
REQ-017 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-018 Latency: start accepted in cycle 0 -> done=1 in cycle BIN_WIDTH+1 -> ready=1 in cycle BIN_WIDTH+2.
REQ-019 start while in SHIFT or DONE SHALL be ignored, with no effect on the operand, counter or result.
REQ-020 bin changes after acceptance SHALL NOT affect the conversion in progress.
REQ-021 Counter width SHALL be clog2(BIN_WIDTH+1); no digit correction is applied after the final shift.
REQ-022 Operand 0 SHALL run the full BIN_WIDTH cycles; there is no early termination.

Reset
REQ-023 rst_n=0 SHALL force state=IDLE, counter=0, working and result registers=0, regardless of clock.
REQ-024 Outputs during and after reset: ready=1, done=0, bcd=0.
REQ-025 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse; the first start after release is accepted normally.

Structure
REQ-026 State encodings and the add-3 threshold constant SHALL live in the shared package.
REQ-027 The per-digit conditional add-3 SHALL be a combinational sub-module bcd_add3 (4-bit in, 4-bit out), instantiated DIGITS times via generate.
REQ-028 The block SHALL be a single registered-state process plus a single next-state process, with no latches.

Verification
REQ-029 bin=0, start pulse -> done in cycle 11, bcd=0x0000, ready high in cycle 12.
REQ-030 bin=1023 -> bcd=0x1023; bin=55 -> bcd=0x0055; bin=89 -> bcd=0x0089.
REQ-031 Exhaustive sweep of bin 0..1023, back-to-back starts issued on ready -> every bcd equals the decimal value, and exactly one done per start.
REQ-032 start held high continuously with bin=144 -> one conversion per 12 cycles, bcd=0x0144, and starts in SHIFT/DONE ignored.
REQ-033 bin=512, then bin=7 driven and start pulsed mid-conversion -> bcd=0x0512, and no second done.
REQ-034 Reset asserted in SHIFT cycle 5 -> ready=1, done=0, bcd=0x0000 immediately; a new start with bin=13 -> bcd=0x0013 with nominal latency.
